ram_fill_writer: RTL and testbench
==================================

# ram_fill_writer

Streaming writer for the 32x3 lab RAMs. Accepts 3-bit words over a valid/ready handshake and writes them into consecutive RAM addresses starting at a programmed base, wrapping modulo depth. It drives the write port (`wraddress`/`datain`/`wren`) of a dual-port RAM whose read port is scanned by the display address counter. It replaces switch-driven single writes with an automated burst fill.

## Interface
Parameters:
- `DATA_WIDTH`, 3, RAM word width
- `ADDR_WIDTH`, 5, RAM address width; depth = 2**ADDR_WIDTH = 32

Ports:
- `clock`  in  1  single clock; all logic on posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a burst; sampled only in IDLE
- `base_addr`  in  ADDR_WIDTH  first write address, latched on accepted `start`
- `length`  in  ADDR_WIDTH+1  words in burst, latched on accepted `start`; 0 means 32, values above 32 saturate to 32
- `abort`  in  1  synchronous cancel of the current burst
- `in_valid`  in  1  source has a word
- `in_data`  in  DATA_WIDTH  word to write
- `in_ready`  out  1  writer accepts a word this cycle
- `wraddress`  out  ADDR_WIDTH  RAM write address (registered)
- `datain`  out  DATA_WIDTH  RAM write data (registered)
- `wren`  out  1  RAM write enable (registered)
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when a burst completes normally
- `count`  out  ADDR_WIDTH+1  words accepted in the current or most recent burst

## Operation
- States: IDLE, CLEAR (only with the macro), FILL, DONE.
- IDLE: `in_ready`=0. `start`=1 latches `base_addr` into the address pointer, latches the effective length, and clears `count` to 0. Next state is CLEAR if the macro is compiled in, otherwise FILL.
- FILL: `in_ready`=1. A transfer occurs on an edge where `in_valid && in_ready`. On a transfer, `datain`<=`in_data`, `wraddress`<=pointer, `wren`<=1, pointer<=pointer+1 mod 32, and `count`<=`count`+1. With no transfer, `wren`<=0.
- When the transfer brings `count` to the effective length, the state goes to DONE. `in_ready` drops in the following cycle, so exactly `length` words are accepted.
- DONE: `done`=1 for exactly one cycle and `wren`=0, then the state returns to IDLE.
- `abort` in CLEAR, FILL or DONE sends the state to IDLE on the next edge with no `done` pulse. A word transferred on that same edge is not accepted, because `abort` wins over the handshake. A write already registered on `wren` still completes. `count` holds its value.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: `abort` wins and the block stays IDLE.
- Address wrap: `base_addr`=30 with length 4 writes addresses 30, 31, 0, 1.
- Length 32 from any base writes every address exactly once.

## Timing
- Reset values, forced asynchronously on `reset_n`=0 including mid-burst: state IDLE, `in_ready`=0, `wren`=0, `wraddress`=0, `datain`=0, `busy`=0, `done`=0, `count`=0, pointer 0.
- `start` accepted at edge N: `busy`=1 from N. `in_ready`=1 from N (no clear) or from N+32 (clear).
- Handshake at edge K: `wren`/`wraddress`/`datain` are valid from K until K+1. RAM write occurs at edge K+1. Latency is 1 cycle.
- Back-to-back throughput is 1 word per cycle.
- The last transfer at edge L gives `done`=1 from L+1 to L+2, and `busy`=0 from L+2.
- `in_ready` depends only on state, never combinationally on `in_valid`.

## Configuration
- Macro `RAM_FILL_CLEAR_EN`.
- Defined: after `start`, CLEAR sweeps all 32 addresses beginning at `base_addr`, writing 0 with `wren`=1, one address per cycle for 32 cycles. `in_ready` stays 0 throughout, and `count` is not incremented. The pointer returns to `base_addr`, then FILL begins. Addresses not reached by the burst read 0 afterward.
- Undefined: the CLEAR state and its logic are absent. `start` goes directly to FILL, and unwritten addresses keep their prior contents.

## Test plan
- Reset, `start` with base 0 and length 32, `in_valid` held high with data 0,1,...,7,0,... → `wren` high for 32 consecutive cycles on addresses 0..31 carrying data i mod 8. `done` pulses once, and `count`=32.
- Base 30, length 4, data 5,6,7,1 with `in_valid` toggled every other cycle → writes (30,5), (31,6), (0,7), (1,1) only on handshake cycles. `in_ready` is 0 after the 4th word.
- Length 0 → treated as 32. Length 40 → saturates to 32. Check `count` and `done` in both cases.
- `abort` asserted after 3 words of a length-10 burst, with `in_valid` high on the abort cycle → exactly 3 writes occur, no `done`, `busy`=0 the next cycle, `count`=3.
- `reset_n` pulsed low mid-burst (asynchronously, between edges) → all outputs read 0 immediately. A following `start` works normally.
- With `RAM_FILL_CLEAR_EN`: base 4, length 2 → 32 zero-writes on addresses 4..31,0..3, then 2 data writes on 4 and 5. `in_ready` first goes high 32 cycles after `start`.

Source files
------------

// File: rtl/ram_fill_writer.sv
// Burst writer into a 32x3 dual-port RAM write port; optional pre-fill zero sweep under RAM_FILL_CLEAR_EN.
// Latency: handshake at edge K drives wren/wraddress/datain from K to K+1.
// Backpressure: in_ready is high only in FILL and depends on state alone, never on in_valid.
`timescale 1ns/1ps
module ram_fill_writer #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] wraddress,
    output logic [DATA_WIDTH-1:0] datain,
    output logic                  wren,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ONE_C   = (ADDR_WIDTH+1)'(1);

`ifdef RAM_FILL_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_FILL = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd2, S_DONE = 2'd3} state_t;
`endif

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH-1:0] r_wraddr;
    logic [DATA_WIDTH-1:0] r_datain;
    logic                  r_wren;
    logic                  r_done;
`ifdef RAM_FILL_CLEAR_EN
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
`endif

    logic [ADDR_WIDTH:0] w_eff_len;
    logic [ADDR_WIDTH:0] w_cnt_nxt;

    // Zero and anything beyond the RAM depth both mean a full-depth burst.
    assign w_eff_len = ((length == '0) || (length > DEPTH_L)) ? DEPTH_L : length;
    assign w_cnt_nxt = r_count + ONE_C;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_len    <= '0;
            r_count  <= '0;
            r_wraddr <= '0;
            r_datain <= '0;
            r_wren   <= 1'b0;
            r_done   <= 1'b0;
`ifdef RAM_FILL_CLEAR_EN
            r_clr_cnt <= '0;
`endif
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !abort) begin
                        r_ptr   <= base_addr;
                        r_len   <= w_eff_len;
                        r_count <= '0;
`ifdef RAM_FILL_CLEAR_EN
                        r_clr_cnt <= '0;
                        r_state   <= S_CLEAR;
`else
                        r_state <= S_FILL;
`endif
                    end
                end
`ifdef RAM_FILL_CLEAR_EN
                S_CLEAR: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        // A full lap of the pointer leaves it back on base_addr for FILL.
                        r_wren    <= 1'b1;
                        r_wraddr  <= r_ptr;
                        r_datain  <= '0;
                        r_ptr     <= r_ptr + ONE_A;
                        r_clr_cnt <= r_clr_cnt + ONE_A;
                        if (r_clr_cnt == '1)
                            r_state <= S_FILL;
                    end
                end
`endif
                S_FILL: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (in_valid) begin
                        r_wren   <= 1'b1;
                        r_wraddr <= r_ptr;
                        r_datain <= in_data;
                        r_ptr    <= r_ptr + ONE_A;
                        r_count  <= w_cnt_nxt;
                        if (w_cnt_nxt == r_len)
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Two cycles here: the first raises done, the second drops it and exits.
                    if (abort) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!r_done) begin
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_FILL);
    assign busy      = (r_state != S_IDLE);
    assign wraddress = r_wraddr;
    assign datain    = r_datain;
    assign wren      = r_wren;
    assign done      = r_done;
    assign count     = r_count;

endmodule

// File: tb/tb_ram_fill_writer.sv
// Directed self-checking bench for ram_fill_writer (default build, plus the clear sweep under RAM_FILL_CLEAR_EN).
`timescale 1ns/1ps
module tb_ram_fill_writer;

`ifdef RAM_FILL_CLEAR_EN
    localparam int CLR = 32;
`else
    localparam int CLR = 0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [4:0] base_addr;
    logic [5:0] length;
    logic       abort;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_ready;
    logic [4:0] wraddress;
    logic [2:0] datain;
    logic       wren;
    logic       busy;
    logic       done;
    logic [5:0] count;

    int n_checks = 0;
    int n_errs   = 0;
    int done_cnt = 0;
    int q_addr[$];
    int q_data[$];

    ram_fill_writer #(.DATA_WIDTH(3), .ADDR_WIDTH(5)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .abort(abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wraddress(wraddress), .datain(datain), .wren(wren),
        .busy(busy), .done(done), .count(count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wren === 1'b1) begin
            q_addr.push_back(int'(wraddress));
            q_data.push_back(int'(datain));
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic do_start(input logic [4:0] b, input logic [5:0] l);
        int w;
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_errs++; $display("FAIL start_busy: got %b want 1", busy); end
        w = 0;
        while (in_ready !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        n_checks++; if (w !== CLR) begin n_errs++; $display("FAIL ready_latency: got %0d want %0d", w, CLR); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_data = 3'd0; base_addr = 5'd0; length = 6'd0;
        #3;
        n_checks++; if (in_ready !== 1'b0) begin n_errs++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_checks++; if (wren !== 1'b0) begin n_errs++; $display("FAIL rst_wren: got %b want 0", wren); end
        n_checks++; if (wraddress !== 5'd0) begin n_errs++; $display("FAIL rst_wraddress: got %0d want 0", wraddress); end
        n_checks++; if (datain !== 3'd0) begin n_errs++; $display("FAIL rst_datain: got %0d want 0", datain); end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errs++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (count !== 6'd0) begin n_errs++; $display("FAIL rst_count: got %0d want 0", count); end
        #9 reset_n = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_fill();
        int d0;
        d0 = done_cnt;
        clear_log();
        do_start(5'd0, 6'd32);
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = 3'(i % 8);
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_errs++; $display("FAIL full_ready_drop: got %b want 0", in_ready); end
        n_checks++; if (done !== 1'b0) begin n_errs++; $display("FAIL full_done_early: got %b want 0", done); end
        tick();
        n_checks++; if (done !== 1'b1) begin n_errs++; $display("FAIL full_done_pulse: got %b want 1", done); end
        n_checks++; if (busy !== 1'b1) begin n_errs++; $display("FAIL full_busy_done: got %b want 1", busy); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL full_busy_end: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errs++; $display("FAIL full_done_end: got %b want 0", done); end
        n_checks++; if (count !== 6'd32) begin n_errs++; $display("FAIL full_count: got %0d want 32", count); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_errs++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt - d0); end
        n_checks++; if (q_addr.size() !== CLR + 32) begin n_errs++; $display("FAIL full_nwrites: got %0d want %0d", q_addr.size(), CLR + 32); end
        if (q_addr.size() == CLR + 32) begin
            for (int i = 0; i < 32; i++) begin
                n_checks++;
                if (q_addr[CLR+i] !== i || q_data[CLR+i] !== i % 8) begin
                    n_errs++;
                    $display("FAIL full_write[%0d]: got (%0d,%0d) want (%0d,%0d)", i, q_addr[CLR+i], q_data[CLR+i], i, i % 8);
                end
            end
        end
    endtask

    task automatic test_wrap_toggle();
        int exp_a[4] = '{30, 31, 0, 1};
        int exp_d[4] = '{5, 6, 7, 1};
        int d0;
        d0 = done_cnt;
        clear_log();
        do_start(5'd30, 6'd4);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 3'(exp_d[i]);
            tick();
            in_valid = 1'b0;
            in_data  = 3'd2;
            if (i < 3) tick();
        end
        n_checks++; if (in_ready !== 1'b0) begin n_errs++; $display("FAIL wrap_ready_drop: got %b want 0", in_ready); end
        tick();
        tick();
        n_checks++; if (count !== 6'd4) begin n_errs++; $display("FAIL wrap_count: got %0d want 4", count); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_errs++; $display("FAIL wrap_done_cnt: got %0d want 1", done_cnt - d0); end
        n_checks++; if (q_addr.size() !== CLR + 4) begin n_errs++; $display("FAIL wrap_nwrites: got %0d want %0d", q_addr.size(), CLR + 4); end
        if (q_addr.size() == CLR + 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (q_addr[CLR+i] !== exp_a[i] || q_data[CLR+i] !== exp_d[i]) begin
                    n_errs++;
                    $display("FAIL wrap_write[%0d]: got (%0d,%0d) want (%0d,%0d)", i, q_addr[CLR+i], q_data[CLR+i], exp_a[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_len_sat(input logic [5:0] l);
        int d0;
        d0 = done_cnt;
        clear_log();
        do_start(5'd5, l);
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = 3'(i % 8);
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_errs++; $display("FAIL len%0d_ready_drop: got %b want 0", l, in_ready); end
        tick();
        tick();
        n_checks++; if (count !== 6'd32) begin n_errs++; $display("FAIL len%0d_count: got %0d want 32", l, count); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_errs++; $display("FAIL len%0d_done_cnt: got %0d want 1", l, done_cnt - d0); end
        n_checks++; if (q_addr.size() !== CLR + 32) begin n_errs++; $display("FAIL len%0d_nwrites: got %0d want %0d", l, q_addr.size(), CLR + 32); end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL len%0d_busy_end: got %b want 0", l, busy); end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        clear_log();
        do_start(5'd10, 6'd10);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 3'(i + 1);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 3'd7;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (wren !== 1'b0) begin n_errs++; $display("FAIL abort_wren: got %b want 0", wren); end
        n_checks++; if (in_ready !== 1'b0) begin n_errs++; $display("FAIL abort_ready: got %b want 0", in_ready); end
        n_checks++; if (count !== 6'd3) begin n_errs++; $display("FAIL abort_count: got %0d want 3", count); end
        tick();
        tick();
        tick();
        n_checks++; if (done_cnt !== d0) begin n_errs++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
        n_checks++; if (q_addr.size() !== CLR + 3) begin n_errs++; $display("FAIL abort_nwrites: got %0d want %0d", q_addr.size(), CLR + 3); end
        if (q_addr.size() == CLR + 3) begin
            n_checks++; if (q_addr[CLR+2] !== 12 || q_data[CLR+2] !== 3) begin n_errs++; $display("FAIL abort_last_write: got (%0d,%0d) want (12,3)", q_addr[CLR+2], q_data[CLR+2]); end
        end
        // start together with abort in IDLE must be ignored
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL start_abort_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_reset_mid_burst();
        int d0;
        do_start(5'd7, 6'd8);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 3'd6;
            tick();
        end
        n_checks++; if (wraddress !== 5'd9) begin n_errs++; $display("FAIL mid_pre_addr: got %0d want 9", wraddress); end
        #3 reset_n = 1'b0;
        #1;
        n_checks++; if (wren !== 1'b0) begin n_errs++; $display("FAIL mid_rst_wren: got %b want 0", wren); end
        n_checks++; if (wraddress !== 5'd0) begin n_errs++; $display("FAIL mid_rst_addr: got %0d want 0", wraddress); end
        n_checks++; if (datain !== 3'd0) begin n_errs++; $display("FAIL mid_rst_data: got %0d want 0", datain); end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_errs++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
        n_checks++; if (count !== 6'd0) begin n_errs++; $display("FAIL mid_rst_count: got %0d want 0", count); end
        in_valid = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        d0 = done_cnt;
        clear_log();
        do_start(5'd3, 6'd2);
        in_valid = 1'b1; in_data = 3'd4; tick();
        in_valid = 1'b1; in_data = 3'd5; tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (count !== 6'd2) begin n_errs++; $display("FAIL post_rst_count: got %0d want 2", count); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_errs++; $display("FAIL post_rst_done: got %0d want 1", done_cnt - d0); end
        n_checks++; if (q_addr.size() !== CLR + 2) begin n_errs++; $display("FAIL post_rst_nwrites: got %0d want %0d", q_addr.size(), CLR + 2); end
        if (q_addr.size() == CLR + 2) begin
            n_checks++; if (q_addr[CLR] !== 3 || q_data[CLR] !== 4) begin n_errs++; $display("FAIL post_rst_w0: got (%0d,%0d) want (3,4)", q_addr[CLR], q_data[CLR]); end
            n_checks++; if (q_addr[CLR+1] !== 4 || q_data[CLR+1] !== 5) begin n_errs++; $display("FAIL post_rst_w1: got (%0d,%0d) want (4,5)", q_addr[CLR+1], q_data[CLR+1]); end
        end
    endtask

`ifdef RAM_FILL_CLEAR_EN
    task automatic test_clear();
        clear_log();
        do_start(5'd4, 6'd2);
        in_valid = 1'b1; in_data = 3'd3; tick();
        in_valid = 1'b1; in_data = 3'd6; tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (q_addr.size() !== 34) begin n_errs++; $display("FAIL clr_nwrites: got %0d want 34", q_addr.size()); end
        if (q_addr.size() == 34) begin
            for (int i = 0; i < 32; i++) begin
                n_checks++;
                if (q_addr[i] !== (4 + i) % 32 || q_data[i] !== 0) begin
                    n_errs++;
                    $display("FAIL clr_sweep[%0d]: got (%0d,%0d) want (%0d,0)", i, q_addr[i], q_data[i], (4 + i) % 32);
                end
            end
            n_checks++; if (q_addr[32] !== 4 || q_data[32] !== 3) begin n_errs++; $display("FAIL clr_w0: got (%0d,%0d) want (4,3)", q_addr[32], q_data[32]); end
            n_checks++; if (q_addr[33] !== 5 || q_data[33] !== 6) begin n_errs++; $display("FAIL clr_w1: got (%0d,%0d) want (5,6)", q_addr[33], q_data[33]); end
        end
        n_checks++; if (count !== 6'd2) begin n_errs++; $display("FAIL clr_count: got %0d want 2", count); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_fill();
        test_wrap_toggle();
        test_len_sat(6'd0);
        test_len_sat(6'd40);
        test_abort();
        test_reset_mid_burst();
`ifdef RAM_FILL_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
